// File: rtl/led_pio_blink.sv
// Memory-mapped LED output port with per-channel blink gating and a shared blink prescaler.
// Optional OUTSET/OUTCLR registers are enabled by defining LED_PIO_BLINK_SETCLR_EN.
module led_pio_blink #(
  parameter int unsigned           WIDTH       = 10,
  parameter logic [WIDTH-1:0]      RESET_VALUE = {WIDTH{1'b1}},
  parameter int unsigned           PRESCALE_W  = 24
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [2:0]               address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  output logic [WIDTH-1:0]         out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
  localparam logic [2:0] ADDR_PERIOD   = 3'd2;
  localparam logic [2:0] ADDR_OUTSET   = 3'd3;
  localparam logic [2:0] ADDR_OUTCLR   = 3'd4;
  localparam logic [2:0] ADDR_STATUS   = 3'd5;

  localparam logic [PRESCALE_W-1:0] CNT_ONE = PRESCALE_W'(1);

  logic [WIDTH-1:0]      r_data;
  logic [WIDTH-1:0]      r_blink_en;
  logic [PRESCALE_W-1:0] r_period;
  logic [PRESCALE_W-1:0] r_cnt;
  logic                  r_phase;

  logic                  w_wr;
  logic [WIDTH-1:0]      w_wdata;
  logic                  w_unused;

  assign w_wr     = chipselect & ~write_n;
  assign w_wdata  = writedata[WIDTH-1:0];
  assign w_unused = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_data     <= RESET_VALUE;
      r_blink_en <= '0;
    end else if (w_wr) begin
      case (address)
        ADDR_DATA:     r_data     <= w_wdata;
        ADDR_BLINK_EN: r_blink_en <= w_wdata;
`ifdef LED_PIO_BLINK_SETCLR_EN
        ADDR_OUTSET:   r_data     <= r_data | w_wdata;
        ADDR_OUTCLR:   r_data     <= r_data & ~w_wdata;
`endif
        default: ;
      endcase
    end
  end

  // A PERIOD write restarts the blink cycle and wins over a coincident terminal count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (w_wr && (address == ADDR_PERIOD)) begin
      r_period <= writedata[PRESCALE_W-1:0];
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (r_period == '0) begin
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else if (r_cnt >= (r_period - CNT_ONE)) begin
      r_cnt    <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_cnt    <= r_cnt + CNT_ONE;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:     readdata = 32'(r_data);
      ADDR_BLINK_EN: readdata = 32'(r_blink_en);
      ADDR_PERIOD:   readdata = 32'(r_period);
      ADDR_STATUS:   readdata = 32'(r_phase);
      default:       readdata = '0;
    endcase
  end

  assign out_port = r_data & ~(r_blink_en & {WIDTH{r_phase}});

endmodule

// File: tb/tb_led_pio_blink.sv
// Scoreboard bench for led_pio_blink (WIDTH=10, PRESCALE_W=24 defaults).
module tb_led_pio_blink;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [9:0]  out_port;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_checks = 0;
  int n_errors = 0;

  led_pio_blink dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop_chk(input logic [31:0] act);
    sb_entry_t e;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, act, e.exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic cs = 1'b1);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = cs;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic read_chk(input string tag, input logic [2:0] a, input logic [31:0] exp);
    sb_push(tag, exp);
    address = a;
    #1;
    sb_pop_chk(readdata);
  endtask

  task automatic out_chk(input string tag, input logic [31:0] exp);
    sb_push(tag, exp);
    #1;
    sb_pop_chk(32'(out_port));
  endtask

  // Push the expected out_port/STATUS pattern for n cycles following a PERIOD write,
  // where the phase flips every `per` clocks, then sample once per cycle.
  task automatic blink_run(input string tag, input int per, input int n,
                           input logic [9:0] data, input logic [9:0] en);
    logic ph;
    for (int k = 0; k < n; k++) begin
      ph = ((k / per) % 2) == 1;
      sb_push({tag, "_out"}, 32'(ph ? (data & ~en) : data));
      sb_push({tag, "_status"}, 32'(ph));
    end
    address = 3'd5;
    for (int k = 0; k < n; k++) begin
      #1;
      sb_pop_chk(32'(out_port));
      sb_pop_chk(readdata);
      @(negedge clk);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    #12;
    out_chk("reset_out", 32'h3FF);
    read_chk("reset_data", 3'd0, 32'h3FF);
    read_chk("reset_en", 3'd1, 32'h0);
    read_chk("reset_period", 3'd2, 32'h0);
    read_chk("reset_status", 3'd5, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    out_chk("post_reset_out", 32'h3FF);

    bus_write(3'd0, 32'hFFFF_F155);
    out_chk("data_wr_out", 32'h155);
    read_chk("data_wr_rd", 3'd0, 32'h155);

    bus_write(3'd0, 32'h0AA, 1'b0);
    read_chk("cs0_ignored", 3'd0, 32'h155);
    bus_write(3'd5, 32'h1);
    bus_write(3'd6, 32'h0AA);
    bus_write(3'd7, 32'h0AA);
    read_chk("unmapped_wr_data", 3'd0, 32'h155);
    read_chk("status_wr_ignored", 3'd5, 32'h0);
    read_chk("unmapped_rd6", 3'd6, 32'h0);

    bus_write(3'd0, 32'h0F0);
    bus_write(3'd3, 32'h003);
`ifdef LED_PIO_BLINK_SETCLR_EN
    read_chk("outset", 3'd0, 32'h0F3);
`else
    read_chk("outset_off", 3'd0, 32'h0F0);
`endif
    bus_write(3'd4, 32'h010);
`ifdef LED_PIO_BLINK_SETCLR_EN
    read_chk("outclr", 3'd0, 32'h0E3);
`else
    read_chk("outclr_off", 3'd0, 32'h0F0);
`endif
    read_chk("outset_rd0", 3'd3, 32'h0);
    read_chk("outclr_rd0", 3'd4, 32'h0);

    bus_write(3'd0, 32'h3FF);
    bus_write(3'd1, 32'h00F);
    read_chk("en_rd", 3'd1, 32'h00F);
    out_chk("en_phase0_out", 32'h3FF);
    bus_write(3'd2, 32'd4);
    read_chk("period_rd", 3'd2, 32'd4);
    blink_run("blink4", 4, 20, 10'h3FF, 10'h00F);

    bus_write(3'd2, 32'd8);
    blink_run("blink8", 8, 6, 10'h3FF, 10'h00F);
    bus_write(3'd2, 32'd2);
    blink_run("shrink2", 2, 9, 10'h3FF, 10'h00F);

    bus_write(3'd2, 32'd2);
    @(negedge clk);
    bus_write(3'd2, 32'd2);
    blink_run("tc_collide", 2, 5, 10'h3FF, 10'h00F);

    bus_write(3'd2, 32'd0);
    for (int k = 0; k < 6; k++) begin
      out_chk("period0_out", 32'h3FF);
      read_chk("period0_status", 3'd5, 32'h0);
      @(negedge clk);
    end

    bus_write(3'd0, 32'h2A5);
    bus_write(3'd1, 32'h0FF);
    bus_write(3'd2, 32'd3);
    blink_run("blink3", 3, 10, 10'h2A5, 10'h0FF);

    bus_write(3'd0, 32'h3FF);
    bus_write(3'd1, 32'h00F);
    bus_write(3'd2, 32'd4);
    repeat (5) @(negedge clk);
    out_chk("pre_reset_phase1", 32'h3F0);
    #2;
    reset_n = 1'b0;
    #1;
    out_chk("async_reset_out", 32'h3FF);
    @(negedge clk);
    reset_n = 1'b1;
    read_chk("rst_en", 3'd1, 32'h0);
    read_chk("rst_period", 3'd2, 32'h0);
    read_chk("rst_data", 3'd0, 32'h3FF);
    repeat (3) @(negedge clk);
    out_chk("rst_idle_out", 32'h3FF);
    bus_write(3'd1, 32'h00F);
    bus_write(3'd2, 32'd3);
    blink_run("after_rst", 3, 8, 10'h3FF, 10'h00F);

    if (sb_q.size() != 0) chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_pio_blink.md
LED_PIO_BLINK -- requirements
Module: led_pio_blink

Interface
REQ-001 Parameter WIDTH, default 10, number of output channels (1..32).
REQ-002 Parameter RESET_VALUE, default all ones (WIDTH bits), reset value of DATA.
REQ-003 Parameter PRESCALE_W, default 24, width of blink period register and counter (1..32).
REQ-004 Port clk  input  1  single clock; all state on rising edge.
REQ-005 Port reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port address  input  3  register word select.
REQ-007 Port chipselect  input  1  slave select.
REQ-008 Port write_n  input  1  active-low write strobe; write = chipselect & ~write_n.
REQ-009 Port writedata  input  32  write data, LSB-aligned.
REQ-010 Port readdata  output  32  read data, LSB-aligned, zero-extended, not inverted.
REQ-011 Port out_port  output  WIDTH  channel drive.

Function
REQ-012 Register map: 0 DATA rw; 1 BLINK_EN rw; 2 PERIOD rw; 3 OUTSET wo; 4 OUTCLR wo; 5 STATUS ro; 6-7 unmapped.
REQ-013 Write to DATA/BLINK_EN loads writedata[WIDTH-1:0] at the clock edge of the write cycle; no wait states.
REQ-014 Write to PERIOD loads writedata[PRESCALE_W-1:0] and, in the same edge, clears blink counter and phase to 0.
REQ-015 OUTSET write: DATA <= DATA | writedata[WIDTH-1:0]; OUTCLR write: DATA <= DATA & ~writedata[WIDTH-1:0].
REQ-016 readdata combinational from address (read latency 0): DATA, BLINK_EN, PERIOD, 0, 0, {31'b0, phase}, 0, 0 for addresses 0..7.
REQ-017 Writes to STATUS and unmapped addresses ignored; writes with chipselect=0 ignored.
REQ-018 Blink counter (PRESCALE_W bits) increments every clock while PERIOD != 0.
REQ-019 When counter >= PERIOD-1: counter <= 0, phase toggles in the same edge (half-period = PERIOD clocks).
REQ-020 PERIOD = 0: counter and phase held at 0 (blink frozen in phase 0).
REQ-021 out_port = DATA & ~(BLINK_EN & {WIDTH{phase}}), registered-free combinational from registered state; channel in blink mode follows DATA in phase 0, forced 0 in phase 1.
REQ-022 PERIOD write coinciding with terminal count: write takes priority (counter 0, phase 0, no toggle).
REQ-023 PERIOD reduced below current count: next edge satisfies REQ-019 compare and wraps; no counter overrun.
REQ-024 out_port changes only at clock edges or reset; no glitching on reads.

Reset
REQ-025 reset_n low asynchronously forces DATA=RESET_VALUE, BLINK_EN=0, PERIOD=0, counter=0, phase=0.
REQ-026 During and immediately after reset out_port = RESET_VALUE; readdata reflects reset register values.
REQ-027 Reset asserted mid-blink abandons count; first toggle after release occurs PERIOD clocks after a nonzero PERIOD write.

Configuration
REQ-028 Macro LED_PIO_BLINK_SETCLR_EN defined: OUTSET/OUTCLR per REQ-015.
REQ-029 Macro LED_PIO_BLINK_SETCLR_EN undefined: addresses 3 and 4 behave as unmapped (writes ignored, read 0); all other behaviour unchanged.

Verification
REQ-030 Reset with WIDTH=10 -> out_port=0x3FF, read addr0=0x3FF, addr1=0, addr2=0, addr5=0.
REQ-031 Write addr0=0x155 -> out_port=0x155 the cycle after write edge; read addr0=0x155.
REQ-032 DATA=0x3FF, BLINK_EN=0x00F, PERIOD=4 -> out_port alternates 0x3FF/0x3F0 every 4 clocks; STATUS bit0 tracks phase.
REQ-033 With SETCLR_EN: DATA=0x0F0, OUTSET 0x003 then OUTCLR 0x010 -> DATA=0x0F3 then 0x0E3; without macro DATA stays 0x0F0.
REQ-034 PERIOD=8, write PERIOD=2 at count 6 -> counter/phase 0, next toggle 2 clocks later; write PERIOD=0 -> out_port=DATA steady.
REQ-035 Assert reset_n mid-blink (phase 1) -> out_port immediately 0x3FF asynchronously, BLINK_EN=0 after release.
